// File: rtl/c3lib_gray_ptr_gen_if.sv
// Pointer-generator bundle: caller drives inc/clr/remote Gray pointer, block returns pointers and flags.
// Optional ptr_level member exists only when C3LIB_GRAY_PTR_LEVEL_EN is defined.
interface c3lib_gray_ptr_gen_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  ptr_inc;
   logic                  ptr_clr;
   logic [ADDR_WIDTH:0]   remote_gray_ptr;
   logic [ADDR_WIDTH-1:0] local_addr;
   logic [ADDR_WIDTH:0]   local_bin_ptr;
   logic [ADDR_WIDTH:0]   local_gray_ptr;
   logic                  ptr_flag;
   logic                  inc_err;
`ifdef C3LIB_GRAY_PTR_LEVEL_EN
   logic [ADDR_WIDTH:0]   ptr_level;
`endif

   modport master (
      output ptr_inc, ptr_clr, remote_gray_ptr,
`ifdef C3LIB_GRAY_PTR_LEVEL_EN
      input  ptr_level,
`endif
      input  local_addr, local_bin_ptr, local_gray_ptr, ptr_flag, inc_err
   );

   modport slave (
      input  ptr_inc, ptr_clr, remote_gray_ptr,
`ifdef C3LIB_GRAY_PTR_LEVEL_EN
      output ptr_level,
`endif
      output local_addr, local_bin_ptr, local_gray_ptr, ptr_flag, inc_err
   );
endinterface

// File: rtl/c3lib_gray_ptr_gen.sv
// Async-FIFO side pointer generator (write: full, read: empty); pointers and flag update 1 cycle after ptr_inc.
// Increments are dropped while the flag is set (inc_err pulses); C3LIB_GRAY_PTR_LEVEL_EN adds a registered ptr_level.
module c3lib_gray_ptr_gen #(
   parameter int ADDR_WIDTH = 4,
   parameter bit RD_SIDE    = 1'b0
) (
   input logic               clk,
   input logic               rst,
   c3lib_gray_ptr_gen_if.slave gp
);
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic RST_FLAG = RD_SIDE ? 1'b1 : 1'b0;
   // Full means the remote pointer is exactly one lap behind: top two Gray bits inverted.
   localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

   logic [PW-1:0] bin_q;
   logic [PW-1:0] gray_q;
   logic          flag_q;
   logic          err_q;
   logic          inc_eff;
   logic [PW-1:0] bin_next;
   logic [PW-1:0] gray_next;
   logic          flag_next;

   always_comb begin
      inc_eff   = gp.ptr_inc & ~flag_q;
      bin_next  = bin_q + PW'(inc_eff);
      gray_next = bin_next ^ (bin_next >> 1);
      if (RD_SIDE)
         flag_next = (gray_next == gp.remote_gray_ptr);
      else
         flag_next = (gray_next == (gp.remote_gray_ptr ^ FULL_MASK));
   end

`ifdef C3LIB_GRAY_PTR_LEVEL_EN
   logic [PW-1:0] remote_bin;
   logic [PW-1:0] level_next;
   logic [PW-1:0] level_q;

   always_comb begin
      remote_bin         = '0;
      remote_bin[PW-1]   = gp.remote_gray_ptr[PW-1];
      for (int i = PW - 2; i >= 0; i--)
         remote_bin[i] = remote_bin[i+1] ^ gp.remote_gray_ptr[i];
      if (RD_SIDE)
         level_next = remote_bin - bin_next;
      else
         level_next = bin_next - remote_bin;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         level_q <= '0;
      else if (gp.ptr_clr)
         level_q <= '0;
      else
         level_q <= level_next;
   end

   assign gp.ptr_level = level_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         flag_q <= RST_FLAG;
         err_q  <= 1'b0;
      end else if (gp.ptr_clr) begin
         bin_q  <= '0;
         gray_q <= '0;
         flag_q <= RST_FLAG;
         err_q  <= 1'b0;
      end else begin
         bin_q  <= bin_next;
         gray_q <= gray_next;
         flag_q <= flag_next;
         err_q  <= gp.ptr_inc & flag_q;
      end
   end

   assign gp.local_addr     = bin_q[ADDR_WIDTH-1:0];
   assign gp.local_bin_ptr  = bin_q;
   assign gp.local_gray_ptr = gray_q;
   assign gp.ptr_flag       = flag_q;
   assign gp.inc_err        = err_q;
endmodule

// File: tb/tb_c3lib_gray_ptr_gen.sv
// Bench for c3lib_gray_ptr_gen: write-side and read-side instances (ADDR_WIDTH=2) against an occupancy model.
// Level checks are active when C3LIB_GRAY_PTR_LEVEL_EN is defined.
module tb_c3lib_gray_ptr_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 1'b0;

   c3lib_gray_ptr_gen_if #(.ADDR_WIDTH(2)) w_if ();
   c3lib_gray_ptr_gen_if #(.ADDR_WIDTH(2)) r_if ();

   c3lib_gray_ptr_gen #(.ADDR_WIDTH(2), .RD_SIDE(1'b0)) u_wr (.clk(clk), .rst(rst), .gp(w_if));
   c3lib_gray_ptr_gen #(.ADDR_WIDTH(2), .RD_SIDE(1'b1)) u_rd (.clk(clk), .rst(rst), .gp(r_if));

   always #5 clk = ~clk;

   // Model: pointers as plain counters mod 8; flags derived from occupancy.
   int m_bin [2];
   int m_flag[2];
   int m_err [2];
   int m_lvl [2];

   function automatic int g2b(input int g);
      int b = 0;
      for (int v = g; v != 0; v = v >> 1) b = b ^ v;
      return b & 7;
   endfunction

   function automatic int b2g(input int b);
      return (b ^ (b >> 1)) & 7;
   endfunction

   task automatic model_step(input int s, input logic inc, input logic clr, input int remote);
      int occ;
      if (rst || clr) begin
         m_bin[s] = 0; m_flag[s] = s; m_err[s] = 0; m_lvl[s] = 0;
      end else begin
         m_err[s] = (inc && m_flag[s] != 0) ? 1 : 0;
         if (inc && m_flag[s] == 0) m_bin[s] = (m_bin[s] + 1) % 8;
         occ = (s == 1) ? ((g2b(remote) - m_bin[s]) & 7) : ((m_bin[s] - g2b(remote)) & 7);
         m_flag[s] = (s == 1) ? int'(occ == 0) : int'(occ == 4);
         m_lvl[s]  = occ;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      model_step(0, w_if.ptr_inc, w_if.ptr_clr, int'(w_if.remote_gray_ptr));
      model_step(1, r_if.ptr_inc, r_if.ptr_clr, int'(r_if.remote_gray_ptr));
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("w_bin",  int'(w_if.local_bin_ptr),  m_bin[0]);
         chk("w_gray", int'(w_if.local_gray_ptr), b2g(m_bin[0]));
         chk("w_addr", int'(w_if.local_addr),     m_bin[0] % 4);
         chk("w_flag", int'(w_if.ptr_flag),       m_flag[0]);
         chk("w_err",  int'(w_if.inc_err),        m_err[0]);
         chk("r_bin",  int'(r_if.local_bin_ptr),  m_bin[1]);
         chk("r_gray", int'(r_if.local_gray_ptr), b2g(m_bin[1]));
         chk("r_addr", int'(r_if.local_addr),     m_bin[1] % 4);
         chk("r_flag", int'(r_if.ptr_flag),       m_flag[1]);
         chk("r_err",  int'(r_if.inc_err),        m_err[1]);
`ifdef C3LIB_GRAY_PTR_LEVEL_EN
         chk("w_lvl",  int'(w_if.ptr_level),      m_lvl[0]);
         chk("r_lvl",  int'(r_if.ptr_level),      m_lvl[1]);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   int exp_g[4] = '{1, 3, 2, 6};

   initial begin
      w_if.ptr_inc = 1'b0; w_if.ptr_clr = 1'b0; w_if.remote_gray_ptr = 3'b000;
      r_if.ptr_inc = 1'b0; r_if.ptr_clr = 1'b0; r_if.remote_gray_ptr = 3'b000;
      step(); step();
      rst = 1'b0;
      chk_en = 1'b1;

      chk("rst_w_gray", int'(w_if.local_gray_ptr), 0);
      chk("rst_w_flag", int'(w_if.ptr_flag), 0);
      chk("rst_w_err",  int'(w_if.inc_err), 0);
      chk("rst_r_flag", int'(r_if.ptr_flag), 1);

      // write-side fill
      w_if.ptr_inc = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("fill_gray", int'(w_if.local_gray_ptr), exp_g[k]);
         if (k == 2) chk("fill_flag_pre", int'(w_if.ptr_flag), 0);
      end
      chk("fill_flag", int'(w_if.ptr_flag), 1);
      chk("fill_bin",  int'(w_if.local_bin_ptr), 4);
      chk("fill_addr", int'(w_if.local_addr), 0);

      // overrun
      for (int k = 0; k < 2; k++) begin
         step();
         chk("ovr_bin", int'(w_if.local_bin_ptr), 4);
         chk("ovr_err", int'(w_if.inc_err), 1);
      end
      w_if.ptr_inc = 1'b0;
      w_if.remote_gray_ptr = 3'b001;
      step();
      chk("ovr_flag_drop", int'(w_if.ptr_flag), 0);
      chk("ovr_err_clear", int'(w_if.inc_err), 0);
      w_if.ptr_inc = 1'b1;
      step();
      w_if.ptr_inc = 1'b0;
      chk("ovr_next_bin", int'(w_if.local_bin_ptr), 5);

      // read side empty
      r_if.ptr_inc = 1'b1;
      step();
      chk("rd_err",  int'(r_if.inc_err), 1);
      chk("rd_bin",  int'(r_if.local_bin_ptr), 0);
      r_if.ptr_inc = 1'b0;
      r_if.remote_gray_ptr = 3'b001;
      step();
      chk("rd_flag_drop", int'(r_if.ptr_flag), 0);
      r_if.ptr_inc = 1'b1;
      step();
      r_if.ptr_inc = 1'b0;
      chk("rd_gray", int'(r_if.local_gray_ptr), 1);
      chk("rd_flag", int'(r_if.ptr_flag), 1);

      // wrap: remote tracks at bin 5, then 7
      w_if.remote_gray_ptr = 3'b111;
      step();
      w_if.ptr_inc = 1'b1;
      step(); step();
      w_if.ptr_inc = 1'b0;
      w_if.remote_gray_ptr = 3'b100;
      step();
      chk("wrap_pre_bin",  int'(w_if.local_bin_ptr), 7);
      chk("wrap_pre_gray", int'(w_if.local_gray_ptr), 4);
      chk("wrap_pre_addr", int'(w_if.local_addr), 3);
      w_if.ptr_inc = 1'b1;
      step();
      w_if.ptr_inc = 1'b0;
      chk("wrap_bin",  int'(w_if.local_bin_ptr), 0);
      chk("wrap_gray", int'(w_if.local_gray_ptr), 0);
      chk("wrap_addr", int'(w_if.local_addr), 0);
      chk("wrap_flag", int'(w_if.ptr_flag), 0);

      // clear priority
      w_if.ptr_inc = 1'b1;
      step(); step();
      chk("clr_pre_bin", int'(w_if.local_bin_ptr), 2);
      w_if.ptr_clr = 1'b1;
      r_if.ptr_clr = 1'b1;
      r_if.ptr_inc = 1'b1;
      step();
      w_if.ptr_clr = 1'b0; w_if.ptr_inc = 1'b0;
      r_if.ptr_clr = 1'b0; r_if.ptr_inc = 1'b0;
      chk("clr_w_bin",  int'(w_if.local_bin_ptr), 0);
      chk("clr_w_err",  int'(w_if.inc_err), 0);
      chk("clr_w_flag", int'(w_if.ptr_flag), 0);
      chk("clr_r_bin",  int'(r_if.local_bin_ptr), 0);
      chk("clr_r_err",  int'(r_if.inc_err), 0);
      chk("clr_r_flag", int'(r_if.ptr_flag), 1);

      // async reset between edges
      w_if.remote_gray_ptr = 3'b000;
      step();
      w_if.ptr_inc = 1'b1;
      step(); step(); step();
      w_if.ptr_inc = 1'b0;
      chk("arst_pre_bin", int'(w_if.local_bin_ptr), 3);
      #1 rst = 1'b1;
      #1;
      chk("arst_w_bin",  int'(w_if.local_bin_ptr), 0);
      chk("arst_w_gray", int'(w_if.local_gray_ptr), 0);
      chk("arst_w_addr", int'(w_if.local_addr), 0);
      chk("arst_w_flag", int'(w_if.ptr_flag), 0);
      chk("arst_r_flag", int'(r_if.ptr_flag), 1);
      step();
      rst = 1'b0;

`ifdef C3LIB_GRAY_PTR_LEVEL_EN
      w_if.ptr_inc = 1'b1;
      step(); step(); step();
      w_if.ptr_inc = 1'b0;
      chk("lvl_three", int'(w_if.ptr_level), 3);
      w_if.remote_gray_ptr = 3'b011;
      step();
      chk("lvl_one", int'(w_if.ptr_level), 1);
      w_if.ptr_inc = 1'b1;
      step(); step(); step();
      w_if.ptr_inc = 1'b0;
      chk("lvl_full", int'(w_if.ptr_level), 4);
      chk("lvl_full_flag", int'(w_if.ptr_flag), 1);
`endif

      step(); step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
